cla_pipe16: RTL

CLA_PIPE16 -- requirements
Module: cla_pipe16

---
 rtl/cla_pkg.sv | 22 ++
 rtl/clg4.sv | 29 ++
 rtl/cla_pipe16.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and the stage-1 record type for the pipelined
// 16-bit carry-lookahead adder/subtractor.
//   CLA_W    datapath width
//   CLA_GRP  width of one lookahead group
//   CLA_NGRP number of first-level groups
//   s1_rec_t per-bit generate/alive/propagate plus carry-in and sign bits
package cla_pkg;

  localparam int CLA_W    = 16;
  localparam int CLA_GRP  = 4;
  localparam int CLA_NGRP = CLA_W / CLA_GRP;

  typedef struct packed {
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] a;
    logic [CLA_W-1:0] p;
    logic             c0;
    logic             xs;
    logic             ys;
  } s1_rec_t;

endpackage

// File: rtl/clg4.sv
// clg4: 4-bit carry lookahead generator (combinational).
// Ports:
//   g[3:0], a[3:0]  per-position generate / alive (transmit) terms
//   cin             carry into position 0
//   c[3:0]          carry into each position (c[0] = cin)
//   g_grp, a_grp    group generate / group alive for the next lookahead level
module clg4
  import cla_pkg::*;
(
  input  logic [CLA_GRP-1:0] g,
  input  logic [CLA_GRP-1:0] a,
  input  logic               cin,
  output logic [CLA_GRP-1:0] c,
  output logic               g_grp,
  output logic               a_grp
);

  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (a[0] & cin);
    c[2] = g[1] | (a[1] & g[0]) | (a[1] & a[0] & cin);
    c[3] = g[2] | (a[2] & g[1]) | (a[2] & a[1] & g[0])
         | (a[2] & a[1] & a[0] & cin);
    g_grp = g[3] | (a[3] & g[2]) | (a[3] & a[2] & g[1])
          | (a[3] & a[2] & a[1] & g[0]);
    a_grp = &a;
  end

endmodule

// File: rtl/cla_pipe16.sv
// cla_pipe16: two-stage pipelined 16-bit carry-lookahead adder/subtractor
// with valid/ready handshakes on both sides.
//   Stage 1 registers per-bit g/a/p, the carry-in and both operand sign bits.
//   Stage 2 resolves carries through a two-level lookahead tree and registers
//   sum, cout and ovf.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; x, y, cin, sub operands
//   out_valid/out_ready result handshake; sum, cout, ovf results
module cla_pipe16
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CLA_W-1:0] x,
  input  logic [CLA_W-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLA_W-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  s1_rec_t          s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [CLA_W-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s2_load;
  logic             in_fire;
  logic [CLA_W-1:0] y_eff;

  logic [CLA_NGRP-1:0] grp_g;
  logic [CLA_NGRP-1:0] grp_a;
  logic [CLA_NGRP-1:0] grp_c;
  logic                top_g;
  logic                top_a;
  logic [CLA_W-1:0]    carry;
  logic                c16;

  // Pipeline control: stage 2 advances when it is empty or being drained;
  // stage 1 can accept when empty or when it is handing off to stage 2.
  always_comb begin
    s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_load;
    in_fire  = in_valid & in_ready;
  end

  // Stage 1: subtraction is X + ~Y + 1, so cin is replaced by 1.
  always_comb begin
    y_eff = sub ? ~y : y;
    s1_d  = s1_q;
    if (in_fire) begin
      s1_d.g  = x & y_eff;
      s1_d.a  = x | y_eff;
      s1_d.p  = x ^ y_eff;
      s1_d.c0 = sub ? 1'b1 : cin;
      s1_d.xs = x[CLA_W-1];
      s1_d.ys = y_eff[CLA_W-1];
    end
    s1_valid_d = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
  end

  // Second-level unit produces the carries into each group (c0/c4/c8/c12).
  clg4 u_clg_top (
    .g     (grp_g),
    .a     (grp_a),
    .cin   (s1_q.c0),
    .c     (grp_c),
    .g_grp (top_g),
    .a_grp (top_a)
  );

  for (genvar gi = 0; gi < CLA_NGRP; gi++) begin : g_grp
    clg4 u_clg (
      .g     (s1_q.g[gi*CLA_GRP +: CLA_GRP]),
      .a     (s1_q.a[gi*CLA_GRP +: CLA_GRP]),
      .cin   (grp_c[gi]),
      .c     (carry[gi*CLA_GRP +: CLA_GRP]),
      .g_grp (grp_g[gi]),
      .a_grp (grp_a[gi])
    );
  end

  // Stage 2: ovf when both effective operands share a sign that the sum lacks.
  always_comb begin
    c16        = top_g | (top_a & s1_q.c0);
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    if (s2_load) begin
      sum_d  = s1_q.p ^ carry;
      cout_d = c16;
      ovf_d  = (s1_q.xs == s1_q.ys) & (sum_d[CLA_W-1] != s1_q.xs);
    end
    s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  // Stage-1 data is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  always_comb begin
    out_valid = s2_valid_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule
